// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan controller:
// active-low segment patterns {a,b,c,d,e,f,g,dp}, ASCII codes, and scan FSM states.
package seg_pkg;

  localparam logic [7:0] SS_0     = 8'h03;
  localparam logic [7:0] SS_1     = 8'h9F;
  localparam logic [7:0] SS_2     = 8'h25;
  localparam logic [7:0] SS_3     = 8'h0D;
  localparam logic [7:0] SS_4     = 8'h99;
  localparam logic [7:0] SS_5     = 8'h49;
  localparam logic [7:0] SS_6     = 8'h41;
  localparam logic [7:0] SS_7     = 8'h1F;
  localparam logic [7:0] SS_8     = 8'h01;
  localparam logic [7:0] SS_9     = 8'h09;
  localparam logic [7:0] SS_A     = 8'h11;
  localparam logic [7:0] SS_B     = 8'hC1;
  localparam logic [7:0] SS_C     = 8'h63;
  localparam logic [7:0] SS_D     = 8'h85;
  localparam logic [7:0] SS_E     = 8'h61;
  localparam logic [7:0] SS_F     = 8'h71;
  localparam logic [7:0] SS_BLANK = 8'hFF;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_F  = 8'h46;
  localparam logic [7:0] ASCII_a  = 8'h61;
  localparam logic [7:0] ASCII_f  = 8'h66;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  typedef enum logic {
    ST_GAP = 1'b0,
    ST_ON  = 1'b1
  } scan_state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] nib;
  } slot_t;

endpackage

// File: rtl/seg_scan_controller_if.sv
// UART-byte input and display-pin output bundle for seg_scan_controller.
// data_valid is a single-cycle strobe with no back-pressure: the byte is taken on every clk edge where it is high.
interface seg_scan_controller_if;
  import seg_pkg::*;

  logic [7:0]  ascii_data;
  logic        data_valid;
  logic [7:0]  seven_segment_data;
  logic [3:0]  seven_segment_enable;
  logic        char_err;
  scan_state_e dbg_state;

  modport master (
    output ascii_data, data_valid,
    input  seven_segment_data, seven_segment_enable, char_err, dbg_state
  );

  modport slave (
    input  ascii_data, data_valid,
    output seven_segment_data, seven_segment_enable, char_err, dbg_state
  );

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low seven-segment pattern (dp always off).
module hex_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [7:0] o_seg
);

  always_comb begin
    o_seg = SS_BLANK;
    case (i_nib)
      4'h0: o_seg = SS_0;
      4'h1: o_seg = SS_1;
      4'h2: o_seg = SS_2;
      4'h3: o_seg = SS_3;
      4'h4: o_seg = SS_4;
      4'h5: o_seg = SS_5;
      4'h6: o_seg = SS_6;
      4'h7: o_seg = SS_7;
      4'h8: o_seg = SS_8;
      4'h9: o_seg = SS_9;
      4'hA: o_seg = SS_A;
      4'hB: o_seg = SS_B;
      4'hC: o_seg = SS_C;
      4'hD: o_seg = SS_D;
      4'hE: o_seg = SS_E;
      4'hF: o_seg = SS_F;
      default: o_seg = SS_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_controller.sv
// Buffers the last four received hex characters and scans them onto a 4-digit
// common-anode display, one digit at a time with an optional all-off gap between digits.
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int GAP_CYCLES   = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg_scan_controller_if.slave  bus
);

  localparam int MAX_CYCLES = (DIGIT_CYCLES > GAP_CYCLES) ? DIGIT_CYCLES : GAP_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  // With no gap configured the scan starts directly in ON so GAP is never visited.
  localparam scan_state_e   RST_STATE  = (GAP_CYCLES > 0) ? ST_GAP : ST_ON;
  localparam scan_state_e   AFTER_ON   = (GAP_CYCLES > 0) ? ST_GAP : ST_ON;

  slot_t       r_buf [4];
  logic        r_char_err;
  scan_state_e r_state;
  scan_state_e w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]  r_idx;
  logic [1:0]  w_idx_nxt;
  logic [7:0]  r_data;
  logic [3:0]  r_en;

  logic        w_is_hex;
  logic        w_is_cr;
  logic [3:0]  w_nib;
  slot_t       w_sel;
  logic [7:0]  w_seg;
  logic [7:0]  w_data_nxt;
  logic [3:0]  w_en_nxt;

  // Letters share low-nibble 1..6 in both cases, so +9 maps them to 10..15.
  always_comb begin
    w_is_hex = 1'b0;
    w_nib    = 4'd0;
    w_is_cr  = (bus.ascii_data == ASCII_CR);
    if (bus.ascii_data >= ASCII_0 && bus.ascii_data <= ASCII_9) begin
      w_is_hex = 1'b1;
      w_nib    = bus.ascii_data[3:0];
    end else if ((bus.ascii_data >= ASCII_A && bus.ascii_data <= ASCII_F) ||
                 (bus.ascii_data >= ASCII_a && bus.ascii_data <= ASCII_f)) begin
      w_is_hex = 1'b1;
      w_nib    = bus.ascii_data[3:0] + 4'd9;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_buf[i] <= '0;
      r_char_err <= 1'b0;
    end else begin
      r_char_err <= bus.data_valid && !w_is_hex && !w_is_cr;
      if (bus.data_valid && w_is_hex) begin
        r_buf[3] <= r_buf[2];
        r_buf[2] <= r_buf[1];
        r_buf[1] <= r_buf[0];
        r_buf[0] <= '{valid: 1'b1, nib: w_nib};
      end else if (bus.data_valid && w_is_cr) begin
        for (int i = 0; i < 4; i++) r_buf[i] <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RST_STATE;
      r_cnt   <= '0;
      r_idx   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_state_nxt = ST_ON;
          w_cnt_nxt   = '0;
        end
      end
      ST_ON: begin
        if (r_cnt == DIGIT_LAST) begin
          w_state_nxt = AFTER_ON;
          w_cnt_nxt   = '0;
          w_idx_nxt   = r_idx + 2'd1;
        end
      end
      default: begin
        w_state_nxt = RST_STATE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_sel = r_buf[r_idx];

  hex_to_seg7 u_dec (
    .i_nib (w_sel.nib),
    .o_seg (w_seg)
  );

  always_comb begin
    w_data_nxt = SS_BLANK;
    w_en_nxt   = 4'b1111;
    if (r_state == ST_ON && w_sel.valid) begin
      w_data_nxt = w_seg;
      w_en_nxt   = ~(4'b0001 << r_idx);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= SS_BLANK;
      r_en   <= 4'b1111;
    end else begin
      r_data <= w_data_nxt;
      r_en   <= w_en_nxt;
    end
  end

  assign bus.seven_segment_data   = r_data;
  assign bus.seven_segment_enable = r_en;
  assign bus.char_err             = r_char_err;
  assign bus.dbg_state            = r_state;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller: a gapped instance checked cycle-by-cycle against a
// time-position reference model, and a gapless instance checked for enable exclusivity.
module tb_seg_scan_controller;

  localparam int D    = 4;
  localparam int G    = 1;
  localparam int SLOT = D + G;
  localparam int SCAN = 4 * SLOT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_controller_if bus0 ();
  seg_scan_controller_if bus1 ();

  seg_scan_controller #(.DIGIT_CYCLES(D), .GAP_CYCLES(G)) dut0 (
    .clk (clk), .rst_n (rst_n), .bus (bus0.slave)
  );
  seg_scan_controller #(.DIGIT_CYCLES(D), .GAP_CYCLES(0)) dut1 (
    .clk (clk), .rst_n (rst_n), .bus (bus1.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  logic chk_on = 1'b0;
  string hex_chars = "0123456789ABCDEFabcdef";

  logic [7:0] seg_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                               8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int hex_val(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    return -1;
  endfunction

  // Reference model: position in the scan is a pure function of edges since reset.
  int         m_n;
  int         m_slot [4];
  logic [7:0] exp_data;
  logic [3:0] exp_en;
  logic [7:0] exp_err;
  int         m1_cnt;
  logic       m1_full;

  always @(posedge clk or negedge rst_n) begin : model
    int p;
    int idx;
    int v;
    if (!rst_n) begin
      m_n      <= 0;
      for (int i = 0; i < 4; i++) m_slot[i] <= -1;
      exp_data <= 8'hFF;
      exp_en   <= 4'hF;
      exp_err  <= 8'd0;
      m1_cnt   <= 0;
      m1_full  <= 1'b0;
    end else begin
      p   = m_n % SCAN;
      idx = p / SLOT;
      if ((p % SLOT) >= G && m_slot[idx] >= 0) begin
        exp_data <= seg_tab[m_slot[idx]];
        exp_en   <= ~(4'b0001 << idx);
      end else begin
        exp_data <= 8'hFF;
        exp_en   <= 4'hF;
      end
      exp_err <= 8'd0;
      m1_full <= (m1_cnt == 4);
      if (bus0.data_valid) begin
        v = hex_val(bus0.ascii_data);
        if (v >= 0) begin
          m_slot[3] <= m_slot[2];
          m_slot[2] <= m_slot[1];
          m_slot[1] <= m_slot[0];
          m_slot[0] <= v;
          if (m1_cnt < 4) m1_cnt <= m1_cnt + 1;
        end else if (bus0.ascii_data == 8'h0D) begin
          for (int i = 0; i < 4; i++) m_slot[i] <= -1;
          m1_cnt <= 0;
        end else begin
          exp_err <= 8'd1;
        end
      end
      m_n <= m_n + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check_val("data0", bus0.seven_segment_data, exp_data);
      check_val("en0", {4'h0, bus0.seven_segment_enable}, {4'h0, exp_en});
      check_val("err0", {7'd0, bus0.char_err}, exp_err);
      check_val("onehot1", 8'($countones(~bus1.seven_segment_enable) <= 1), 8'd1);
      check_val("err1", {7'd0, bus1.char_err}, exp_err);
      if (m1_full) check_val("nogap1", 8'(bus1.seven_segment_enable != 4'hF), 8'd1);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int idle);
    @(negedge clk);
    bus0.ascii_data = b; bus0.data_valid = 1'b1;
    bus1.ascii_data = b; bus1.data_valid = 1'b1;
    @(negedge clk);
    bus0.data_valid = 1'b0;
    bus1.data_valid = 1'b0;
    repeat (idle) @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Async reset a few ns after an edge, check outputs immediately, then release on a negedge.
  task automatic pulse_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_en0", {4'h0, bus0.seven_segment_enable}, 8'h0F);
    check_val("rst_data0", bus0.seven_segment_data, 8'hFF);
    check_val("rst_en1", {4'h0, bus1.seven_segment_enable}, 8'h0F);
    check_val("rst_data1", bus1.seven_segment_data, 8'hFF);
    check_val("rst_err1", {7'd0, bus1.char_err}, 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] rand_byte();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 6) return hex_chars[$urandom_range(0, 21)];
    if (sel < 7) return 8'h0D;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin : stim
    logic hit;
    bus0.ascii_data = 8'h00; bus0.data_valid = 1'b0;
    bus1.ascii_data = 8'h00; bus1.data_valid = 1'b0;
    chk_on = 1'b1;
    idle_cycles(5);
    rst_n = 1'b1;
    idle_cycles(10);

    send_byte("1", 0); send_byte("2", 0); send_byte("3", 0); send_byte("4", 2 * SCAN);

    send_byte(8'h0D, 0); send_byte("a", 0); send_byte("5", 2 * SCAN);

    send_byte("G", 3); send_byte(8'h0D, SCAN);

    send_byte("9", 0); send_byte("b", 0); send_byte("C", 0); send_byte("e", 3);
    hit = 1'b0;
    for (int i = 0; i < 2 * SCAN; i++) begin
      @(negedge clk);
      if (m_n % SCAN == SCAN - 1) begin
        hit = 1'b1;
        break;
      end
    end
    check_val("wrap_wait", 8'(hit), 8'd1);
    bus0.ascii_data = "7"; bus0.data_valid = 1'b1;
    bus1.ascii_data = "7"; bus1.data_valid = 1'b1;
    @(negedge clk);
    bus0.data_valid = 1'b0; bus1.data_valid = 1'b0;
    idle_cycles(SCAN + 3);

    send_byte("F", 0); send_byte("0", 0); send_byte("d", 0); send_byte("8", 6);
    pulse_reset();
    idle_cycles(SCAN);

    for (int i = 0; i < 300; i++) begin
      send_byte(rand_byte(), $urandom_range(0, 8));
      if ($urandom_range(0, 39) == 0) pulse_reset();
    end
    idle_cycles(SCAN);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
